// File: rtl/mcu51_ifetch.sv
// MCU51 instruction fetch: owns the PC and reads 1-3 bytes per instruction from a byte-wide ROM.
// It presents each complete instruction to the decoder over valid/ready. Redirects override any fetch.
module mcu51_ifetch #(
  parameter int                   ADDRWIDTH = 8,
  parameter logic [ADDRWIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 rom_cs_n,
  output logic [ADDRWIDTH-1:0] rom_addr,
  input  logic [7:0]           rom_data,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [7:0]           instr_op,
  output logic [7:0]           instr_b1,
  output logic [7:0]           instr_b2,
  output logic [1:0]           instr_len,
  output logic [ADDRWIDTH-1:0] instr_pc,
  input  logic                 jmp_valid,
  input  logic [ADDRWIDTH-1:0] jmp_target
);

  typedef enum logic [1:0] {S_OP, S_B1, S_B2, S_OUT} state_t;

  state_t               state_q, state_d;
  logic [ADDRWIDTH-1:0] pc_q, pc_d;
  logic                 cs_n_q, cs_n_d;
  logic [7:0]           op_q, op_d, b1_q, b1_d, b2_q, b2_d;
  logic [1:0]           len_q, len_d;
  logic [ADDRWIDTH-1:0] ipc_q, ipc_d;

  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] l;
    case (op) inside
      8'h75, 8'h85, 8'hD5, [8'hB4:8'hBF]:
        l = 2'd3;
      8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35, 8'h44, 8'h45, 8'h54, 8'h55,
      8'h60, 8'h70, 8'h74, [8'h76:8'h7F], 8'h80, [8'h86:8'h8F], 8'h94, 8'h95,
      [8'hA6:8'hAF], [8'hD8:8'hDF], 8'hE5, 8'hF5:
        l = 2'd2;
      default:
        l = 2'd1;
    endcase
    return l;
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    len_d   = len_q;
    ipc_d   = ipc_q;
    case (state_q)
      S_OP: begin
        // cs_n is still high on the first cycle out of reset, so no byte is valid yet
        if (!cs_n_q) begin
          op_d    = rom_data;
          b1_d    = 8'h00;
          b2_d    = 8'h00;
          ipc_d   = pc_q;
          pc_d    = pc_q + 1'b1;
          len_d   = op_len(rom_data);
          state_d = (len_d == 2'd1) ? S_OUT : S_B1;
        end
      end
      S_B1: begin
        b1_d    = rom_data;
        pc_d    = pc_q + 1'b1;
        state_d = (len_q == 2'd3) ? S_B2 : S_OUT;
      end
      S_B2: begin
        b2_d    = rom_data;
        pc_d    = pc_q + 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (instr_ready) state_d = S_OP;
      end
      default: state_d = S_OP;
    endcase
    if (jmp_valid) begin
      pc_d    = jmp_target;
      state_d = S_OP;
    end
    cs_n_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OP;
      pc_q    <= RESET_PC;
      cs_n_q  <= 1'b1;
      op_q    <= 8'h00;
      b1_q    <= 8'h00;
      b2_q    <= 8'h00;
      len_q   <= 2'd1;
      ipc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cs_n_q  <= cs_n_d;
      op_q    <= op_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      len_q   <= len_d;
      ipc_q   <= ipc_d;
    end
  end

  assign rom_cs_n    = cs_n_q;
  assign rom_addr    = pc_q;
  assign instr_valid = (state_q == S_OUT);
  assign instr_op    = op_q;
  assign instr_b1    = b1_q;
  assign instr_b2    = b2_q;
  assign instr_len   = len_q;
  assign instr_pc    = ipc_q;

endmodule
